trdb_itype_detector_ras: RTL and testbench

//  Registered instruction-type classifier for the trace encoder with implicit-return support.

---
 rtl/trdb_itype_detector_ras_if.sv | 51 +++++
 rtl/trdb_itype_detector_ras.sv | 170 +++++++++++++++++
 tb/tb_trdb_itype_detector_ras.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/trdb_itype_detector_ras_if.sv
// Interface: trdb_itype_detector_ras_if
// Groups the retirement-side inputs and the classified outputs of the
// instruction-type detector. The detector connects through the slave modport.
// The retirement source and packet emitter (or a testbench) use the master modport.
//
//   valid_i         retired instruction present this cycle
//   inst_data_i     instruction word (compressed: low 16 bits significant)
//   compressed_i    instruction is 16-bit
//   iaddr_i         address of this instruction
//   next_iaddr_i    address of next retired instruction
//   implicit_ret_i  implicit-return mode enable
//   flush_i         clear the return-address stack
//   valid_o .. ras_depth_o   registered classification results
interface trdb_itype_detector_ras_if #(
    parameter int IADDR_W   = 32,
    parameter int RAS_DEPTH = 8
);
    localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

    logic               valid_i;
    logic [31:0]        inst_data_i;
    logic               compressed_i;
    logic [IADDR_W-1:0] iaddr_i;
    logic [IADDR_W-1:0] next_iaddr_i;
    logic               implicit_ret_i;
    logic               flush_i;

    logic               valid_o;
    logic               is_branch_o;
    logic               is_branch_taken_o;
    logic               updiscon_o;
    logic               is_call_o;
    logic               is_ret_o;
    logic               ret_implicit_o;
    logic               ras_overflow_o;
    logic [DEPTH_W-1:0] ras_depth_o;

    modport master (
        output valid_i, inst_data_i, compressed_i, iaddr_i, next_iaddr_i,
               implicit_ret_i, flush_i,
        input  valid_o, is_branch_o, is_branch_taken_o, updiscon_o, is_call_o,
               is_ret_o, ret_implicit_o, ras_overflow_o, ras_depth_o
    );

    modport slave (
        input  valid_i, inst_data_i, compressed_i, iaddr_i, next_iaddr_i,
               implicit_ret_i, flush_i,
        output valid_o, is_branch_o, is_branch_taken_o, updiscon_o, is_call_o,
               is_ret_o, ret_implicit_o, ras_overflow_o, ras_depth_o
    );
endinterface

// File: rtl/trdb_itype_detector_ras.sv
// Module: trdb_itype_detector_ras
// Registered instruction-type classifier for the trace encoder. Each retired
// instruction is decoded into branch/taken, call, return and uninferable
// discontinuity flags one cycle after it is presented. Calls push their return
// address onto a circular return-address stack. A return whose target matches
// the stack top is reported as an implicit return instead of a discontinuity.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous reset, active low
//   bus      trdb_itype_detector_ras_if.slave (retirement inputs, classified outputs)
module trdb_itype_detector_ras #(
    parameter int IADDR_W   = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    trdb_itype_detector_ras_if.slave     bus
);
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(RAS_DEPTH);

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // ------------------------------------------------------------------
    // Instruction decode (combinational)
    // ------------------------------------------------------------------
    logic [31:0]        inst;
    logic [IADDR_W-1:0] seq_addr;
    logic               dec_branch;
    logic               dec_call;
    logic               dec_ret;
    logic               dec_updiscon;

    assign inst     = bus.inst_data_i;
    // Sequential successor; wraps modulo 2^IADDR_W by width truncation.
    assign seq_addr = bus.iaddr_i + (bus.compressed_i ? IADDR_W'(2) : IADDR_W'(4));

    always_comb begin
        dec_branch   = 1'b0;
        dec_call     = 1'b0;
        dec_ret      = 1'b0;
        dec_updiscon = 1'b0;
        if (!bus.compressed_i) begin
            unique case (inst[6:0])
                // All funct3 values: the base branches plus p.beqimm/p.bneimm.
                7'b1100011: dec_branch = 1'b1;
                7'b1101111: dec_call   = is_link(inst[11:7]);
                7'b1100111: begin
                    dec_updiscon = 1'b1;
                    dec_call     = is_link(inst[11:7]);
                    // rd=link excludes this, so a coroutine jump counts as a call only.
                    dec_ret      = (inst[11:7] == 5'd0) && is_link(inst[19:15]) &&
                                   (inst[31:20] == 12'd0);
                end
                default: begin
                    // MRET, SRET, URET
                    if (inst == 32'h3020_0073 || inst == 32'h1020_0073 ||
                        inst == 32'h0020_0073) begin
                        dec_updiscon = 1'b1;
                    end
                end
            endcase
        end else begin
            if (inst[1:0] == 2'b01) begin
                // c.jal (RV32) is a call; c.j is neither call nor discontinuity.
                if (inst[15:13] == 3'b001) dec_call = 1'b1;
                if (inst[15:14] == 2'b11)  dec_branch = 1'b1;   // c.beqz / c.bnez
            end else if (inst[1:0] == 2'b10 && inst[15:13] == 3'b100 &&
                         inst[11:7] != 5'd0 && inst[6:2] == 5'd0) begin
                dec_updiscon = 1'b1;
                if (inst[12]) begin
                    dec_call = 1'b1;                            // c.jalr
                end else begin
                    dec_ret  = is_link(inst[11:7]);             // c.jr
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack next state
    // ------------------------------------------------------------------
    logic [IADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_eff;
    logic [DEPTH_W-1:0] depth_q, depth_d, depth_eff;
    logic [IADDR_W-1:0] top;
    logic               ras_clear;
    logic               push;
    logic               ret_chk;
    logic               ret_hit;
    logic               overflow;

    // Disabling implicit-return mode holds the stack empty, like a flush.
    assign ras_clear = bus.flush_i || !bus.implicit_ret_i;
    assign ptr_eff   = ras_clear ? '0 : ptr_q;
    assign depth_eff = ras_clear ? '0 : depth_q;
    assign top       = ras_q[ptr_eff - PTR_W'(1)];

    assign push     = bus.valid_i && dec_call && bus.implicit_ret_i;
    assign ret_chk  = bus.valid_i && dec_ret && bus.implicit_ret_i;
    assign ret_hit  = ret_chk && (depth_eff != '0) && (bus.next_iaddr_i == top);
    assign overflow = push && (depth_eff == FULL);

    always_comb begin
        ptr_d   = ptr_eff;
        depth_d = depth_eff;
        if (push) begin
            // When full the pointer wraps onto the oldest entry and depth saturates.
            ptr_d = ptr_eff + PTR_W'(1);
            if (depth_eff != FULL) depth_d = depth_eff + DEPTH_W'(1);
        end else if (ret_hit) begin
            ptr_d   = ptr_eff - PTR_W'(1);
            depth_d = depth_eff - DEPTH_W'(1);
        end else if (ret_chk && depth_eff != '0) begin
            // Mismatched return: stack contents no longer trusted.
            ptr_d   = '0;
            depth_d = '0;
        end
    end

    // Stack storage carries data only; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (push) ras_q[ptr_eff] <= seq_addr;
    end

    // ------------------------------------------------------------------
    // Registered control and outputs
    // ------------------------------------------------------------------
    logic valid_q, branch_q, taken_q, updiscon_q, call_q, ret_q, ret_impl_q, ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            depth_q    <= '0;
            valid_q    <= 1'b0;
            branch_q   <= 1'b0;
            taken_q    <= 1'b0;
            updiscon_q <= 1'b0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            ret_impl_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            depth_q    <= depth_d;
            valid_q    <= bus.valid_i;
            branch_q   <= bus.valid_i && dec_branch;
            taken_q    <= bus.valid_i && dec_branch && (bus.next_iaddr_i != seq_addr);
            updiscon_q <= bus.valid_i && dec_updiscon && !ret_hit;
            call_q     <= bus.valid_i && dec_call;
            ret_q      <= bus.valid_i && dec_ret;
            ret_impl_q <= ret_hit;
            ovf_q      <= overflow;
        end
    end

    assign bus.valid_o           = valid_q;
    assign bus.is_branch_o       = branch_q;
    assign bus.is_branch_taken_o = taken_q;
    assign bus.updiscon_o        = updiscon_q;
    assign bus.is_call_o         = call_q;
    assign bus.is_ret_o          = ret_q;
    assign bus.ret_implicit_o    = ret_impl_q;
    assign bus.ras_overflow_o    = ovf_q;
    assign bus.ras_depth_o       = depth_q;
endmodule

// File: tb/tb_trdb_itype_detector_ras.sv
module tb_trdb_itype_detector_ras;
    localparam int IADDR_W   = 32;
    localparam int RAS_DEPTH = 8;

    localparam logic [31:0] I_BEQ    = 32'h0000_0063;
    localparam logic [31:0] I_JAL_RA = 32'h0000_00EF;
    localparam logic [31:0] I_RET    = 32'h0000_8067;
    localparam logic [31:0] I_JALR_C = 32'h0005_00E7;  // jalr ra, 0(a0)
    localparam logic [31:0] I_CJALR  = 32'h0000_9502;  // c.jalr a0
    localparam logic [31:0] I_CRET   = 32'h0000_8082;  // c.jr ra
    localparam logic [31:0] I_CJ     = 32'h0000_A001;  // c.j
    localparam logic [31:0] I_MRET   = 32'h3020_0073;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    trdb_itype_detector_ras_if #(.IADDR_W(IADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    trdb_itype_detector_ras #(.IADDR_W(IADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction, then land 1ns after the capturing edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic c,
                        input logic [31:0] ia, input logic [31:0] nia, input logic fl);
        bus.valid_i      = v;
        bus.inst_data_i  = inst;
        bus.compressed_i = c;
        bus.iaddr_i      = ia;
        bus.next_iaddr_i = nia;
        bus.flush_i      = fl;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.valid_i        = 1'b0;
        bus.inst_data_i    = '0;
        bus.compressed_i   = 1'b0;
        bus.iaddr_i        = '0;
        bus.next_iaddr_i   = '0;
        bus.implicit_ret_i = 1'b1;
        bus.flush_i        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_depth", 64'(bus.ras_depth_o), 64'd0);
        chk("rst_call", 64'(bus.is_call_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Branch not taken / taken
        bus.valid_i = 1'b1;
        bus.inst_data_i = I_BEQ;
        #1;
        chk("beq_valid_before_edge", 64'(bus.valid_o), 64'd0);
        #1;
        step(1'b1, I_BEQ, 1'b0, 32'h100, 32'h104, 1'b0);
        chk("beq_valid", 64'(bus.valid_o), 64'd1);
        chk("beq_branch", 64'(bus.is_branch_o), 64'd1);
        chk("beq_nt_taken", 64'(bus.is_branch_taken_o), 64'd0);
        step(1'b1, I_BEQ, 1'b0, 32'h100, 32'h80, 1'b0);
        chk("beq_taken", 64'(bus.is_branch_taken_o), 64'd1);
        step(1'b0, I_BEQ, 1'b0, 32'h100, 32'h80, 1'b0);
        chk("idle_valid", 64'(bus.valid_o), 64'd0);
        chk("idle_branch", 64'(bus.is_branch_o), 64'd0);

        // Call then matched return
        step(1'b1, I_JAL_RA, 1'b0, 32'h200, 32'h400, 1'b0);
        chk("jal_call", 64'(bus.is_call_o), 64'd1);
        chk("jal_updiscon", 64'(bus.updiscon_o), 64'd0);
        chk("jal_depth", 64'(bus.ras_depth_o), 64'd1);
        step(1'b1, I_RET, 1'b0, 32'h400, 32'h204, 1'b0);
        chk("ret_is_ret", 64'(bus.is_ret_o), 64'd1);
        chk("ret_implicit", 64'(bus.ret_implicit_o), 64'd1);
        chk("ret_updiscon", 64'(bus.updiscon_o), 64'd0);
        chk("ret_depth", 64'(bus.ras_depth_o), 64'd0);

        // Mismatched return
        step(1'b1, I_JAL_RA, 1'b0, 32'h200, 32'h400, 1'b0);
        step(1'b1, I_RET, 1'b0, 32'h400, 32'h300, 1'b0);
        chk("mis_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("mis_implicit", 64'(bus.ret_implicit_o), 64'd0);
        chk("mis_depth", 64'(bus.ras_depth_o), 64'd0);

        // Implicit-return mode off
        bus.implicit_ret_i = 1'b0;
        step(1'b1, I_JAL_RA, 1'b0, 32'h200, 32'h400, 1'b0);
        chk("off_call", 64'(bus.is_call_o), 64'd1);
        chk("off_depth_call", 64'(bus.ras_depth_o), 64'd0);
        step(1'b1, I_RET, 1'b0, 32'h400, 32'h204, 1'b0);
        chk("off_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("off_implicit", 64'(bus.ret_implicit_o), 64'd0);
        chk("off_depth_ret", 64'(bus.ras_depth_o), 64'd0);
        bus.implicit_ret_i = 1'b1;

        // Nine nested calls into an eight-entry stack
        for (int k = 0; k < 9; k++) begin
            step(1'b1, I_JAL_RA, 1'b0, 32'h1000 + 32'(k) * 32'h10, 32'h8000, 1'b0);
            chk($sformatf("nest_depth_%0d", k), 64'(bus.ras_depth_o), (k < 8) ? 64'(k + 1) : 64'd8);
            chk($sformatf("nest_ovf_%0d", k), 64'(bus.ras_overflow_o), (k == 8) ? 64'd1 : 64'd0);
        end
        for (int k = 8; k >= 1; k--) begin
            step(1'b1, I_RET, 1'b0, 32'h8000, 32'h1004 + 32'(k) * 32'h10, 1'b0);
            chk($sformatf("unwind_impl_%0d", k), 64'(bus.ret_implicit_o), 64'd1);
            chk($sformatf("unwind_depth_%0d", k), 64'(bus.ras_depth_o), 64'(k - 1));
        end
        step(1'b1, I_RET, 1'b0, 32'h8000, 32'h1004, 1'b0);
        chk("unwind_lost_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("unwind_lost_implicit", 64'(bus.ret_implicit_o), 64'd0);

        // Compressed call at top of address space: return address wraps to 0
        step(1'b1, I_CJALR, 1'b1, 32'hFFFF_FFFE, 32'h3000, 1'b0);
        chk("cjalr_call", 64'(bus.is_call_o), 64'd1);
        chk("cjalr_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("cjalr_depth", 64'(bus.ras_depth_o), 64'd1);
        step(1'b1, I_CRET, 1'b1, 32'h3000, 32'h0, 1'b0);
        chk("cret_wrap_implicit", 64'(bus.ret_implicit_o), 64'd1);
        chk("cret_wrap_depth", 64'(bus.ras_depth_o), 64'd0);

        // c.j and jalr-call classification
        step(1'b1, I_CJ, 1'b1, 32'h3100, 32'h3200, 1'b0);
        chk("cj_updiscon", 64'(bus.updiscon_o), 64'd0);
        chk("cj_call", 64'(bus.is_call_o), 64'd0);
        step(1'b1, I_JALR_C, 1'b0, 32'h3200, 32'h5000, 1'b0);
        chk("jalr_call", 64'(bus.is_call_o), 64'd1);
        chk("jalr_updiscon", 64'(bus.updiscon_o), 64'd1);

        // Flush with a call in the same cycle
        step(1'b1, I_JAL_RA, 1'b0, 32'h500, 32'h600, 1'b0);
        chk("pre_flush_depth", 64'(bus.ras_depth_o), 64'd2);
        step(1'b1, I_JAL_RA, 1'b0, 32'h700, 32'h900, 1'b1);
        chk("flush_call_depth", 64'(bus.ras_depth_o), 64'd1);
        step(1'b1, I_RET, 1'b0, 32'h900, 32'h704, 1'b0);
        chk("flush_call_ret_impl", 64'(bus.ret_implicit_o), 64'd1);

        // Flush with a return in the same cycle
        step(1'b1, I_JAL_RA, 1'b0, 32'hA00, 32'hB00, 1'b0);
        step(1'b1, I_RET, 1'b0, 32'hB00, 32'hA04, 1'b1);
        chk("flush_ret_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("flush_ret_implicit", 64'(bus.ret_implicit_o), 64'd0);
        chk("flush_ret_depth", 64'(bus.ras_depth_o), 64'd0);

        // MRET
        step(1'b1, I_MRET, 1'b0, 32'hC00, 32'h80, 1'b0);
        chk("mret_updiscon", 64'(bus.updiscon_o), 64'd1);
        chk("mret_is_ret", 64'(bus.is_ret_o), 64'd0);

        // Asynchronous reset mid-stack
        step(1'b1, I_JAL_RA, 1'b0, 32'hD00, 32'hE00, 1'b0);
        step(1'b1, I_JAL_RA, 1'b0, 32'hE00, 32'hF00, 1'b0);
        chk("prerst_depth", 64'(bus.ras_depth_o), 64'd2);
        chk("prerst_call", 64'(bus.is_call_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_depth", 64'(bus.ras_depth_o), 64'd0);
        chk("arst_valid", 64'(bus.valid_o), 64'd0);
        chk("arst_call", 64'(bus.is_call_o), 64'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
